// File: rtl/apb_pkg.sv
// Shared definitions for the APB3 master bridge: FSM encoding, data width and error response value.
package apb_pkg;

    localparam int APB_DW = 32;
    localparam logic [APB_DW-1:0] ERR_RDATA = '0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    // Width of a counter that must hold values 0..max_val (never narrower than 1 bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/apb_slv_decode.sv
// Address-to-slave decoder: one-hot select from the slave-index field, error when the index has no slave.
module apb_slv_decode
    import apb_pkg::*;
#(
    parameter int AW      = 16,
    parameter int NSLV    = 4,
    parameter int SLV_LSB = 12,
    parameter int IW      = 2
) (
    input  logic [AW-1:0]   addr,
    output logic [NSLV-1:0] sel,
    output logic            decode_err
);

    logic [IW-1:0] idx;
    logic [AW-1:0] unused_addr;

    assign idx         = addr[SLV_LSB +: IW];
    assign unused_addr = addr;
    assign decode_err  = (32'(idx) >= 32'(NSLV));

    // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NSLV; i++) begin
            sel[i] = (idx == IW'(i));
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 initiator: accepts one CPU req/gnt transaction at a time, runs SETUP/ACCESS on the decoded
// slave, and returns read data or an error (slave error, decode error, timeout) as a one-cycle rvalid.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int AW      = 16,
    parameter int NSLV    = 4,
    parameter int SLV_LSB = 12,
    parameter int IW      = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                   apb_pclk,
    input  logic                   apb_prst,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [AW-1:0]          cpu_addr,
    input  logic [APB_DW-1:0]      cpu_wdata,
    output logic                   cpu_gnt,
    output logic                   cpu_rvalid,
    output logic [APB_DW-1:0]      cpu_rdata,
    output logic                   cpu_err,
    output logic [NSLV-1:0]        apb_psel,
    output logic                   apb_penable,
    output logic                   apb_pwrite,
    output logic [AW-1:0]          apb_paddr,
    output logic [APB_DW-1:0]      apb_pwdata,
    input  logic [NSLV*APB_DW-1:0] apb_prdata,
    input  logic [NSLV-1:0]        apb_pready,
    input  logic [NSLV-1:0]        apb_pslverr
);

    localparam int CW = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    apb_state_e state_q, state_d;

    logic                 we_q;
    logic [AW-1:0]        addr_q;
    logic [APB_DW-1:0]    wdata_q;
    logic [NSLV-1:0]      sel_q;
    logic [CW-1:0]        tcnt_q;
    logic [APB_DW-1:0]    rdata_q;
    logic                 err_q;

    logic [NSLV-1:0]      dec_sel;
    logic                 dec_err;
    logic                 sel_ready;
    logic                 sel_err;
    logic [APB_DW-1:0]    sel_rdata;
    logic                 access_done;
    logic                 access_abort;

    apb_slv_decode #(
        .AW      (AW),
        .NSLV    (NSLV),
        .SLV_LSB (SLV_LSB),
        .IW      (IW)
    ) u_decode (
        .addr       (cpu_addr),
        .sel        (dec_sel),
        .decode_err (dec_err)
    );

    // Only the latched target slave's response lines reach the FSM.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (sel_q[i]) begin
                sel_ready = apb_pready[i];
                sel_err   = apb_pslverr[i];
                sel_rdata = apb_prdata[APB_DW*i +: APB_DW];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cpu_gnt      = 1'b0;
        access_done  = 1'b0;
        access_abort = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    cpu_gnt = 1'b1;
                    state_d = dec_err ? ST_RESP : ST_SETUP;
                end
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (sel_ready) begin
                    access_done = 1'b1;
                    state_d     = ST_RESP;
                end else if ((TIMEOUT != 0) && (tcnt_q == TO_LAST)) begin
                    access_abort = 1'b1;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge apb_pclk or posedge apb_prst) begin
        if (apb_prst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge apb_pclk or posedge apb_prst) begin
        if (apb_prst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            tcnt_q  <= '0;
            rdata_q <= ERR_RDATA;
            err_q   <= 1'b0;
        end else begin
            if (cpu_gnt) begin
                we_q    <= cpu_we;
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
                sel_q   <= dec_sel;
                tcnt_q  <= '0;
                if (dec_err) begin
                    rdata_q <= ERR_RDATA;
                    err_q   <= 1'b1;
                end
            end
            if ((state_q == ST_ACCESS) && !sel_ready && (tcnt_q != '1)) begin
                tcnt_q <= tcnt_q + CW'(1);
            end
            if (access_done) begin
                err_q   <= sel_err;
                rdata_q <= (we_q || sel_err) ? ERR_RDATA : sel_rdata;
            end
            if (access_abort) begin
                err_q   <= 1'b1;
                rdata_q <= ERR_RDATA;
            end
        end
    end

    // APB and CPU outputs decode straight from flops, so reset clears them without a clock edge.
    assign apb_psel    = ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) ? sel_q : '0;
    assign apb_penable = (state_q == ST_ACCESS);
    assign apb_pwrite  = we_q;
    assign apb_paddr   = addr_q;
    assign apb_pwdata  = we_q ? wdata_q : '0;

    assign cpu_rvalid  = (state_q == ST_RESP);
    assign cpu_rdata   = cpu_rvalid ? rdata_q : ERR_RDATA;
    assign cpu_err     = cpu_rvalid && err_q;

    a_psel_onehot: assert property (@(posedge apb_pclk) disable iff (apb_prst) $onehot0(apb_psel));
    a_penable_sel: assert property (@(posedge apb_pclk) disable iff (apb_prst) apb_penable |-> (apb_psel != '0));

endmodule
